// File: rtl/wb_soc_slave_regs.sv
// Wishbone B3 classic slave register block: ADDR config word, CTRL (irq enable,
// init clear), STATUS (sticky W1C pending, initialized) and a read-only ID.
// Every access terminates one cycle after the request is seen.
module wb_soc_slave_regs #(
  parameter logic [31:0] ID_VALUE  = 32'h56494F00,
  parameter logic [31:0] REG_RESET = 32'h41000000
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic        raise_irq,
  output logic        irq,
  output logic [31:0] module_register,
  output logic        initialized,
  input  logic [31:0] p_wb_reg_DAT_I,
  output logic [31:0] p_wb_reg_DAT_O,
  input  logic [31:0] p_wb_reg_ADR_I,
  output logic        p_wb_reg_ACK_O,
  input  logic        p_wb_reg_CYC_I,
  output logic        p_wb_reg_ERR_O,
  input  logic        p_wb_reg_LOCK_I,
  output logic        p_wb_reg_RTY_O,
  input  logic [3:0]  p_wb_reg_SEL_I,
  input  logic        p_wb_reg_STB_I,
  input  logic        p_wb_reg_WE_I
);

  localparam logic [1:0] REG_ADDR   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  logic [31:0] addr_q, addr_d;
  logic        init_q, init_d;
  logic        irq_en_q, irq_en_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  logic        req;
  logic        wr;
  logic        rd;
  logic [1:0]  reg_sel;
  logic        unused_ok;

  // Lock, low address bits and upper address bits carry no meaning here.
  assign unused_ok = ^{p_wb_reg_LOCK_I, p_wb_reg_ADR_I[31:4], p_wb_reg_ADR_I[1:0]};

  // A new request is only accepted while no termination is on the bus, which
  // forces the one-access-per-two-cycles cadence.
  assign req     = p_wb_reg_CYC_I & p_wb_reg_STB_I & ~(ack_q | err_q);
  assign wr      = req & p_wb_reg_WE_I;
  assign rd      = req & ~p_wb_reg_WE_I;
  assign reg_sel = p_wb_reg_ADR_I[3:2];

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Read-data selection from the current register state.
  function automatic logic [31:0] read_mux(input logic [1:0]  rsel,
                                           input logic [31:0] addr_w,
                                           input logic        en,
                                           input logic        init,
                                           input logic        pend);
    logic [31:0] res;
    res = 32'h0;
    case (rsel)
      REG_ADDR:   res = addr_w;
      REG_CTRL:   res = {31'h0, en};
      REG_STATUS: res = {30'h0, init, pend};
      default:    res = ID_VALUE;
    endcase
    return res;
  endfunction

  // Next-state decode of bus terminations, register writes and interrupt state.
  always_comb begin
    addr_d   = addr_q;
    init_d   = init_q;
    irq_en_d = irq_en_q;
    pend_d   = pend_q;
    ack_d    = req & ~(p_wb_reg_WE_I & (reg_sel == REG_ID));
    err_d    = wr & (reg_sel == REG_ID);
    dat_d    = 32'h0;
    irq_d    = pend_q & irq_en_q;

    if (rd) begin
      dat_d = read_mux(reg_sel, addr_q, irq_en_q, init_q, pend_q);
    end

    if (wr) begin
      case (reg_sel)
        REG_ADDR: begin
          addr_d = merge_bytes(addr_q, p_wb_reg_DAT_I, p_wb_reg_SEL_I);
          init_d = 1'b1;
        end
        REG_CTRL: begin
          if (p_wb_reg_SEL_I[0]) begin
            irq_en_d = p_wb_reg_DAT_I[0];
            if (p_wb_reg_DAT_I[1]) init_d = 1'b0;
          end
        end
        REG_STATUS: begin
          if (p_wb_reg_SEL_I[0] && p_wb_reg_DAT_I[0]) pend_d = 1'b0;
        end
        default: ;
      endcase
    end

    // A new event always wins over a same-cycle clear.
    if (raise_irq) pend_d = 1'b1;
  end

  // State registers; reset drops any access in flight with no termination.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      addr_q   <= REG_RESET;
      init_q   <= 1'b0;
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= 32'h0;
    end else begin
      addr_q   <= addr_d;
      init_q   <= init_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
    end
  end

  assign irq             = irq_q;
  assign module_register = addr_q;
  assign initialized     = init_q;
  assign p_wb_reg_DAT_O  = dat_q;
  assign p_wb_reg_ACK_O  = ack_q;
  assign p_wb_reg_ERR_O  = err_q;
  assign p_wb_reg_RTY_O  = 1'b0;

endmodule

// File: tb/tb_wb_soc_slave_regs.sv
// Self-checking bench for wb_soc_slave_regs: directed scenarios followed by
// random per-cycle bus and event traffic, compared every cycle to a
// behavioural register-file model.
module tb_wb_soc_slave_regs;

  localparam logic [31:0] ID_VAL  = 32'h56494F00;
  localparam logic [31:0] RST_VAL = 32'h41000000;

  logic        p_clk = 1'b0;
  logic        p_resetn = 1'b0;
  logic        raise_irq = 1'b0;
  logic        irq;
  logic [31:0] module_register;
  logic        initialized;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat_o;
  logic [31:0] adr_i = 32'h0;
  logic        ack_o;
  logic        cyc_i = 1'b0;
  logic        err_o;
  logic        lock_i = 1'b0;
  logic        rty_o;
  logic [3:0]  sel_i = 4'h0;
  logic        stb_i = 1'b0;
  logic        we_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  wb_soc_slave_regs dut (
    .p_clk           (p_clk),
    .p_resetn        (p_resetn),
    .raise_irq       (raise_irq),
    .irq             (irq),
    .module_register (module_register),
    .initialized     (initialized),
    .p_wb_reg_DAT_I  (dat_i),
    .p_wb_reg_DAT_O  (dat_o),
    .p_wb_reg_ADR_I  (adr_i),
    .p_wb_reg_ACK_O  (ack_o),
    .p_wb_reg_CYC_I  (cyc_i),
    .p_wb_reg_ERR_O  (err_o),
    .p_wb_reg_LOCK_I (lock_i),
    .p_wb_reg_RTY_O  (rty_o),
    .p_wb_reg_SEL_I  (sel_i),
    .p_wb_reg_STB_I  (stb_i),
    .p_wb_reg_WE_I   (we_i)
  );

  always #5 p_clk = ~p_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the register file as the programmer sees it, plus the
  // one-cycle termination and the registered irq.
  logic [31:0] m_addr;
  logic        m_init, m_en, m_pend, m_irq, m_ack, m_err;
  logic [31:0] m_dat;

  always @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      m_addr = RST_VAL; m_init = 0; m_en = 0; m_pend = 0;
      m_irq = 0; m_ack = 0; m_err = 0; m_dat = 0;
    end else begin
      logic accept;
      logic [1:0] r;
      logic clr;
      accept = stb_i && cyc_i && !m_ack && !m_err;
      r = adr_i[3:2];
      m_irq = m_pend && m_en;
      m_dat = 0;
      clr = 0;
      if (accept && !we_i) begin
        if (r == 0) m_dat = m_addr;
        else if (r == 1) m_dat = m_en ? 32'd1 : 32'd0;
        else if (r == 2) m_dat = (m_init ? 32'd2 : 32'd0) + (m_pend ? 32'd1 : 32'd0);
        else m_dat = ID_VAL;
      end
      if (accept && we_i) begin
        if (r == 0) begin
          for (int b = 0; b < 4; b++)
            if (sel_i[b]) m_addr[8*b +: 8] = dat_i[8*b +: 8];
          m_init = 1;
        end else if (r == 1 && sel_i[0]) begin
          m_en = dat_i[0];
          if (dat_i[1]) m_init = 0;
        end else if (r == 2 && sel_i[0] && dat_i[0]) begin
          clr = 1;
        end
      end
      if (raise_irq) m_pend = 1;
      else if (clr) m_pend = 0;
      m_err = accept && we_i && (r == 3);
      m_ack = accept && !(we_i && (r == 3));
    end
  end

  // Every cycle, compare all outputs to the model away from the clock edge.
  always @(negedge p_clk) begin
    check("ack", {31'h0, ack_o}, {31'h0, m_ack});
    check("err", {31'h0, err_o}, {31'h0, m_err});
    check("rty", {31'h0, rty_o}, 32'h0);
    check("dat_o", dat_o, m_dat);
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    check("module_register", module_register, m_addr);
    check("initialized", {31'h0, initialized}, {31'h0, m_init});
  end

  // One bus access; returns the termination flags and read data seen in the
  // termination cycle.
  task automatic bus_access(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                            input logic [31:0] wdat, output logic [31:0] rdat,
                            output logic ack, output logic err);
    @(posedge p_clk); #2;
    stb_i = 1; cyc_i = 1; we_i = we; adr_i = {28'h0, adr}; sel_i = sel; dat_i = wdat;
    @(posedge p_clk); #2;
    rdat = dat_o; ack = ack_o; err = err_o;
    stb_i = 0; cyc_i = 0; we_i = 0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] rd; logic a, e;
    bus_access(1'b1, adr, sel, d, rd, a, e);
    check("wr_ack", {31'h0, a}, 32'h1);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] rd; logic a, e;
    bus_access(1'b0, adr, 4'hF, 32'h0, rd, a, e);
    check({tag, "_ack"}, {31'h0, a}, 32'h1);
    check(tag, rd, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge p_clk);
    #2;
  endtask

  initial begin
    logic [31:0] rd; logic a, e;
    // Reset and ID read right after release.
    idle(3);
    p_resetn = 1;
    rd_chk("id_after_reset", 4'hC, ID_VAL);

    // ADDR full write sets initialized; STATUS shows it.
    wr(4'h0, 4'hF, 32'h40001000);
    check("addr_full", module_register, 32'h40001000);
    check("init_set", {31'h0, initialized}, 32'h1);
    rd_chk("addr_readback", 4'h0, 32'h40001000);
    rd_chk("status_init", 4'h8, 32'h2);

    // Asynchronous reset mid-cycle, mid-access.
    @(posedge p_clk); #2;
    stb_i = 1; cyc_i = 1; we_i = 1; adr_i = 0; sel_i = 4'hF; dat_i = 32'h12345678;
    #1 p_resetn = 0;
    #1;
    check("rst_reg", module_register, RST_VAL);
    check("rst_init", {31'h0, initialized}, 32'h0);
    check("rst_ack", {31'h0, ack_o}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    stb_i = 0; cyc_i = 0; we_i = 0;
    idle(2);
    p_resetn = 1;

    // Byte lanes from reset value.
    wr(4'h0, 4'b0101, 32'hAABBCCDD);
    check("byte_lanes", module_register, 32'h41BB00DD);
    wr(4'h0, 4'b0000, 32'hFFFFFFFF);
    check("sel0_keeps", module_register, 32'h41BB00DD);

    // CLR_INIT, CTRL readback.
    wr(4'h4, 4'h1, 32'h2);
    check("clr_init", {31'h0, initialized}, 32'h0);
    rd_chk("ctrl_reads0", 4'h4, 32'h0);

    // IRQ masked while pending accumulates.
    @(posedge p_clk); #2 raise_irq = 1;
    @(posedge p_clk); #2 raise_irq = 0;
    idle(2);
    check("irq_masked", {31'h0, irq}, 32'h0);
    rd_chk("status_pend", 4'h8, 32'h1);
    wr(4'h4, 4'hF, 32'h1);
    idle(1);
    check("irq_enabled", {31'h0, irq}, 32'h1);
    wr(4'h8, 4'h1, 32'h1);
    idle(1);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // Set wins over W1C in the same cycle.
    raise_irq = 1;
    idle(2);
    check("irq_raised", {31'h0, irq}, 32'h1);
    wr(4'h8, 4'h1, 32'h1);
    idle(1);
    raise_irq = 0;
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    rd_chk("status_set_wins", 4'h8, 32'h1);

    // ID write errors without side effects.
    bus_access(1'b1, 4'hC, 4'hF, 32'hDEADBEEF, rd, a, e);
    check("id_wr_err", {31'h0, e}, 32'h1);
    check("id_wr_noack", {31'h0, a}, 32'h0);
    rd_chk("id_unchanged", 4'hC, ID_VAL);

    // Random per-cycle traffic, including held strobes and aborts.
    for (int i = 0; i < 3000; i++) begin
      @(posedge p_clk); #2;
      cyc_i = ($urandom_range(0, 9) != 0);
      stb_i = ($urandom_range(0, 2) != 0);
      we_i = $urandom_range(0, 1);
      adr_i = $urandom;
      sel_i = $urandom;
      dat_i = ($urandom_range(0, 1) != 0) ? $urandom : {30'h0, 2'($urandom)};
      raise_irq = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 p_resetn = 0;
        #2 p_resetn = 1;
      end
    end
    stb_i = 0; cyc_i = 0; raise_irq = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
